// File: rtl/pulse_pkg.sv
// Shared types and default timing constants for the pulse stretcher and the button debouncer.
package pulse_pkg;

  // 100 ms at 50 MHz; the debouncer's divn_num uses the same value
  localparam int unsigned DIVN_NUM     = 5000000;
  localparam int unsigned DEF_HOLD_NUM = DIVN_NUM;
  localparam int unsigned DEF_GAP_NUM  = DIVN_NUM;
  localparam int unsigned DEF_CNT_W    = 26;
  localparam int unsigned DEF_PEND_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter of queued requests, with a sticky overflow flag for dropped increments.
module pend_counter
  import pulse_pkg::*;
#(
  parameter int unsigned PEND_W = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              full,
  output logic              ovf
);

  assign full = (count == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc && !dec) begin
      if (full) ovf <= 1'b1;
      else      count <= count + PEND_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - PEND_W'(1);
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle request pulses into HOLD_NUM-cycle active levels separated by
// at least GAP_NUM inactive cycles; requests arriving while busy are queued.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int unsigned HOLD_NUM   = DEF_HOLD_NUM,
  parameter int unsigned GAP_NUM    = DEF_GAP_NUM,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned PEND_W     = DEF_PEND_W,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               level_nxt, busy_nxt;
  logic               hold_last, gap_last, pend_nz;
  logic               start, take;
  logic               pend_inc, pend_dec, pend_full;

  assign hold_last = (cnt == CNT_W'(HOLD_NUM - 1));
  assign gap_last  = (cnt == CNT_W'(GAP_NUM - 1));
  assign pend_nz   = (pending != '0);

  assign start = ((state == ST_IDLE) || ((state == ST_GAP) && gap_last)) && (pend_nz || pulse_in);
  assign take  = start && pend_nz;

  // A start with nothing queued consumes pulse_in directly; a start that takes the
  // oldest queued request while pulse_in is high leaves the queue depth unchanged.
  assign pend_inc = pulse_in && !start;
  assign pend_dec = take && !pulse_in;

  pend_counter #(
    .PEND_W(PEND_W)
  ) u_pend (
    .clk  (clk),
    .rst  (rst),
    .inc  (pend_inc),
    .dec  (pend_dec),
    .count(pending),
    .full (pend_full),
    .ovf  (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      level_out <= ACTIVE_LOW;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      level_out <= level_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_last) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          state_nxt = start ? ST_HOLD : ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so level_out follows pulse_in by one edge
  always_comb begin
    level_nxt = (state_nxt == ST_HOLD) ^ ACTIVE_LOW;
    busy_nxt  = (state_nxt != ST_IDLE);
  end

  assert property (@(posedge clk) disable iff (rst)
    (pend_inc && !pend_dec && pend_full) |=> overflow);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: two stretchers (active-high and active-low) driven with identical stimulus.
module tb_pulse_stretcher;

  localparam int unsigned PW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pulse_in = 1'b0;
  logic          lvl_h, busy_h, ovf_h;
  logic          lvl_l, busy_l, ovf_l;
  logic [PW-1:0] pend_h, pend_l;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  localparam string G0 = "0000000000";
  localparam string Z  = "0000000000000000000000000000000000000000";

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HOLD_NUM(4), .GAP_NUM(2), .CNT_W(8), .PEND_W(PW), .ACTIVE_LOW(1'b0)
  ) dut_h (
    .clk(clk), .rst(rst), .pulse_in(pulse_in),
    .level_out(lvl_h), .busy(busy_h), .pending(pend_h), .overflow(ovf_h)
  );

  pulse_stretcher #(
    .HOLD_NUM(4), .GAP_NUM(2), .CNT_W(8), .PEND_W(PW), .ACTIVE_LOW(1'b1)
  ) dut_l (
    .clk(clk), .rst(rst), .pulse_in(pulse_in),
    .level_out(lvl_l), .busy(busy_l), .pending(pend_l), .overflow(ovf_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    pulse_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.level_h", 32'(lvl_h), 32'd0);
    check("rst.level_l", 32'(lvl_l), 32'd1);
    check("rst.busy",    32'(busy_h), 32'd0);
    check("rst.pending", 32'(pend_h), 32'd0);
    check("rst.overflow", 32'(ovf_h), 32'd0);
    rst      = 1'b0;
    pulse_in = 1'b0;
  endtask

  // Each string holds one character per clock edge; expected values are those seen just after that edge.
  task automatic run_case(input string name, input string p, input string r, input string lv,
                          input string bz, input string pd, input string ov);
    logic [31:0] exp_l, exp_b, exp_p, exp_o;
    for (int e = 0; e < 40; e++) begin
      rst      = (r[e] == "1");
      pulse_in = (p[e] == "1");
      @(posedge clk);
      #1;
      exp_l = (lv[e] == "1") ? 32'd1 : 32'd0;
      exp_b = (bz[e] == "1") ? 32'd1 : 32'd0;
      exp_o = (ov[e] == "1") ? 32'd1 : 32'd0;
      exp_p = 32'(int'(pd[e]) - 48);
      check($sformatf("%s.level_h[%0d]", name, e), 32'(lvl_h), exp_l);
      check($sformatf("%s.level_l[%0d]", name, e), 32'(lvl_l), exp_l ^ 32'd1);
      check($sformatf("%s.busy_h[%0d]", name, e), 32'(busy_h), exp_b);
      check($sformatf("%s.busy_l[%0d]", name, e), 32'(busy_l), exp_b);
      check($sformatf("%s.pending[%0d]", name, e), 32'(pend_h), exp_p);
      check($sformatf("%s.pending_l[%0d]", name, e), 32'(pend_l), exp_p);
      check($sformatf("%s.overflow[%0d]", name, e), 32'(ovf_h), exp_o);
      check($sformatf("%s.overflow_l[%0d]", name, e), 32'(ovf_l), exp_o);
    end
    rst      = 1'b0;
    pulse_in = 1'b0;
  endtask

  initial begin
    // single pulse: idle edges 0-9, hold after edges 10-13, gap 14-15
    do_reset();
    run_case("single",
      {G0, "1000000000", G0, G0}, Z,
      {G0, "1111000000", G0, G0},
      {G0, "1111110000", G0, G0},
      Z, Z);

    // three pulses: queued, served back-to-back with exactly two gap cycles
    do_reset();
    run_case("three",
      {G0, "1110000000", G0, G0}, Z,
      {G0, "1111001111", "0011110000", G0},
      {G0, "1111111111", "1111111100", G0},
      {G0, "0122221111", "1100000000", G0},
      Z);

    // five pulses: pending saturates at 3, fifth request dropped, four holds
    do_reset();
    run_case("sat",
      {G0, "1111100000", G0, G0}, Z,
      {G0, "1111001111", "0011110011", "1100000000"},
      {G0, "1111111111", "1111111111", "1111000000"},
      {G0, "0123332222", "2211111100", G0},
      {G0, "0000111111", "1111111111", "1111111111"});

    // reset mid-hold with pending=2 and a simultaneous pulse: everything cleared
    do_reset();
    run_case("midrst",
      {"0000000001", "1110000000", G0, G0},
      {G0, "0010000000", G0, G0},
      {"0000000001", "1100000000", G0, G0},
      {"0000000001", "1100000000", G0, G0},
      {G0, "1200000000", G0, G0},
      Z);

    // pulse on the last gap cycle with nothing queued restarts hold without idling
    do_reset();
    run_case("gapstart",
      {G0, "1000001000", G0, G0}, Z,
      {G0, "1111001111", G0, G0},
      {G0, "1111111111", "1100000000", G0},
      Z, Z);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
